// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate-decode stage
// Contents:
//   imm_fmt_e   3-bit immediate format code (NONE,I,S,B,U,J,SH,Z)
//   OPC_*       RV32/RV64 base opcodes recognised by the decoder
//   xlen_legal  elaboration-time check that XLEN is 32 or 64
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - input/output handshake bundle of the immediate-decode stage
// Signals:
//   in_valid/in_ready/in_instr/in_pc                      producer side
//   out_valid/out_ready/out_imm/out_fmt/out_target/
//   out_pc/out_illegal                                     consumer side
// Modports: master = whoever drives inputs and consumes outputs; slave = the stage.
interface imm_decode_stage_if #(parameter int XLEN = 32);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
  );

endinterface

// File: rtl/imm_fmt_decode.sv
// rtl/imm_fmt_decode.sv - combinational opcode-to-format detection and immediate extension
// Ports:
//   instr    in   32    raw instruction word
//   fmt      out  3     detected immediate format
//   imm      out  XLEN  extended immediate
//   pc_rel   out  1     immediate is a PC offset (branch, JAL, AUIPC)
//   illegal  out  1     unsupported opcode, bad low bits, or RV32 shamt[5] set
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm,
  output logic            pc_rel,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    fmt    = FMT_NONE;
    pc_rel = 1'b0;
    case (opcode)
      OPC_LUI:              fmt = FMT_U;
      OPC_AUIPC:            begin fmt = FMT_U; pc_rel = 1'b1; end
      OPC_JAL:              begin fmt = FMT_J; pc_rel = 1'b1; end
      OPC_BRANCH:           begin fmt = FMT_B; pc_rel = 1'b1; end
      OPC_STORE:            fmt = FMT_S;
      OPC_LOAD, OPC_JALR:   fmt = FMT_I;
      OPC_OP_IMM:           fmt = is_shift ? FMT_SH : FMT_I;
      OPC_OP_IMM_32: begin
        // The W-form opcode only exists on RV64.
        if (XLEN == 64) fmt = is_shift ? FMT_SH : FMT_I;
      end
      OPC_SYSTEM:           fmt = funct3[2] ? FMT_Z : FMT_I;
      default:              fmt = FMT_NONE;
    endcase
  end

  // Signed size casts do the sign extension from instr[31] to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(instr[31:20]));
      FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_SH: begin
        // 5-bit shamt on RV32 and for the 32-bit W shifts; 6-bit otherwise.
        if ((XLEN == 32) || (opcode == OPC_OP_IMM_32)) imm = XLEN'(instr[24:20]);
        else                                           imm = XLEN'(instr[25:20]);
      end
      FMT_Z: imm = XLEN'(instr[19:15]);
      default: imm = '0;
    endcase
  end

  assign illegal = (fmt == FMT_NONE) || (instr[1:0] != 2'b11) ||
                   ((fmt == FMT_SH) && (XLEN == 32) && instr[25]);

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate-decode stage with PC-relative adder and 2-entry skid buffer
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   flush  in   1   drop every buffered entry and the entry offered this cycle
//   bus    slave modport of imm_decode_stage_if (in_* producer side, out_* consumer side)
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  imm_decode_stage_if.slave  bus
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_pc_rel;
  logic            dec_illegal;

  imm_fmt_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .pc_rel  (dec_pc_rel),
    .illegal (dec_illegal)
  );

  entry_t new_entry;
  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.target  = dec_pc_rel ? (bus.in_pc + dec_imm) : '0;  // wraps mod 2^XLEN
    new_entry.pc      = bus.in_pc;
    new_entry.illegal = dec_illegal;
  end

  entry_t main_q, main_n, skid_q, skid_n;
  logic   main_v, main_v_n, skid_v, skid_v_n;
  logic   in_ready_q;
  logic   accept, xfer;

  assign accept = bus.in_valid && in_ready_q && !flush;
  assign xfer   = main_v && bus.out_ready;

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    main_n   = main_q;
    skid_n   = skid_q;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (xfer || !main_v) begin
      // Main is free this edge: the older skid entry has priority. When the
      // skid is full in_ready was low, so no new entry can arrive alongside.
      if (skid_v) begin
        main_n   = skid_q;
        main_v_n = 1'b1;
        skid_v_n = 1'b0;
      end else begin
        main_v_n = accept;
        if (accept) main_n = new_entry;
      end
    end else if (accept) begin
      skid_n   = new_entry;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      main_v     <= main_v_n;
      skid_v     <= skid_v_n;
      main_q     <= main_n;
      skid_q     <= skid_n;
      // Registered copy of !skid_valid keeps out_ready off the in_ready path.
      in_ready_q <= !skid_v_n;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_v;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_target  = main_q.target;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for imm_decode_stage at XLEN=32 and XLEN=64
module tb_imm_decode_stage;
  import imm_pkg::*;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        ill;
  } obs_t;

  typedef struct packed {
    logic [31:0] instr;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) if32();
  imm_decode_stage_if #(.XLEN(64)) if64();

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32.slave));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(if64.slave));

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t exp32[$];
  obs_t exp64[$];

  function automatic obs_t sample(input bit sel64);
    obs_t o;
    if (sel64) begin
      o.imm = if64.out_imm; o.fmt = if64.out_fmt; o.tgt = if64.out_target;
      o.pc  = if64.out_pc;  o.ill = if64.out_illegal;
    end else begin
      o.imm = 64'(if32.out_imm); o.fmt = if32.out_fmt; o.tgt = 64'(if32.out_target);
      o.pc  = 64'(if32.out_pc);  o.ill = if32.out_illegal;
    end
    return o;
  endfunction

  task automatic send(input bit sel64, input logic [31:0] instr, input logic [63:0] pc, output bit ok);
    if (sel64) begin if64.in_valid = 1'b1; if64.in_instr = instr; if64.in_pc = pc; end
    else begin if32.in_valid = 1'b1; if32.in_instr = instr; if32.in_pc = pc[31:0]; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel64 ? if64.in_ready : if32.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    if (sel64) if64.in_valid = 1'b0; else if32.in_valid = 1'b0;
  endtask

  task automatic collect(input bit sel64, output obs_t o, output bit ok);
    if (sel64) if64.out_ready = 1'b1; else if32.out_ready = 1'b1;
    ok = 1'b0;
    o  = '0;
    for (int i = 0; i < 20; i++) begin
      if (sel64 ? if64.out_valid : if32.out_valid) begin o = sample(sel64); ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    if (sel64) if64.out_ready = 1'b0; else if32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.in_instr = '0; if32.in_pc = '0;
    if64.in_valid = 1'b0; if64.out_ready = 1'b0; if64.in_instr = '0; if64.in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32: got %b want 0", if32.out_valid); end
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready32: got %b want 0", if32.in_ready); end
    n_cmp++; if (sample(1'b0) !== obs_t'(0)) begin n_fail++; $display("FAIL reset_data32: got %h want 0", sample(1'b0)); end
    n_cmp++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid64: got %b want 0", if64.out_valid); end
    n_cmp++; if (sample(1'b1) !== obs_t'(0)) begin n_fail++; $display("FAIL reset_data64: got %h want 0", sample(1'b1)); end
    rst = 1'b0;
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fall_in_ready: got %b want 0", if32.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_after_in_ready32: got %b want 1", if32.in_ready); end
    n_cmp++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_after_in_ready64: got %b want 1", if64.in_ready); end
  endtask

  task automatic test_formats32();
    vec_t t[11];
    obs_t o, e;
    bit   oks, okc;
    t = '{
      '{32'hFFF00093, '{64'hFFFFFFFF, 3'd1, 64'h0,        64'h0,    1'b0}},
      '{32'hFE000EE3, '{64'hFFFFFFFC, 3'd3, 64'hFC,       64'h100,  1'b0}},
      '{32'hFE000EE3, '{64'hFFFFFFFC, 3'd3, 64'hFFFFFFFC, 64'h0,    1'b0}},
      '{32'h03F09093, '{64'h1F,       3'd6, 64'h0,        64'h40,   1'b1}},
      '{32'h0080006F, '{64'h8,        3'd5, 64'h208,      64'h200,  1'b0}},
      '{32'hFE112E23, '{64'hFFFFFFFC, 3'd2, 64'h0,        64'h300,  1'b0}},
      '{32'h300FD073, '{64'h1F,       3'd7, 64'h0,        64'h304,  1'b0}},
      '{32'h0010809B, '{64'h0,        3'd0, 64'h0,        64'h308,  1'b1}},
      '{32'h00000001, '{64'h0,        3'd0, 64'h0,        64'h30C,  1'b1}},
      '{32'hFFFFF097, '{64'hFFFFF000, 3'd4, 64'h1000,     64'h2000, 1'b0}},
      '{32'hFFC08067, '{64'hFFFFFFFC, 3'd1, 64'h0,        64'h400,  1'b0}}
    };
    foreach (t[i]) begin
      exp32.push_back(t[i].exp);
      send(1'b0, t[i].instr, t[i].exp.pc, oks);
      collect(1'b0, o, okc);
      e = exp32.pop_front();
      n_cmp++;
      if (!oks || !okc) begin n_fail++; $display("FAIL fmt32[%0d]: timeout send=%b collect=%b want 1/1", i, oks, okc); end
      else if (o !== e) begin n_fail++; $display("FAIL fmt32[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_formats64();
    vec_t t[7];
    obs_t o, e;
    bit   oks, okc;
    t = '{
      '{32'h03F09093, '{64'h3F,               3'd6, 64'h0,               64'h40,               1'b0}},
      '{32'h800000B7, '{64'hFFFFFFFF80000000, 3'd4, 64'h0,               64'h80,               1'b0}},
      '{32'h00000000, '{64'h0,                3'd0, 64'h0,               64'h84,               1'b1}},
      '{32'h00001097, '{64'h1000,             3'd4, 64'h800,             64'hFFFFFFFFFFFFF800, 1'b0}},
      '{32'h0010809B, '{64'h1,                3'd1, 64'h0,               64'h88,               1'b0}},
      '{32'h01F0909B, '{64'h1F,               3'd6, 64'h0,               64'h8C,               1'b0}},
      '{32'hFE000EE3, '{64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h0,                1'b0}}
    };
    foreach (t[i]) begin
      exp64.push_back(t[i].exp);
      send(1'b1, t[i].instr, t[i].exp.pc, oks);
      collect(1'b1, o, okc);
      e = exp64.pop_front();
      n_cmp++;
      if (!oks || !okc) begin n_fail++; $display("FAIL fmt64[%0d]: timeout send=%b collect=%b want 1/1", i, oks, okc); end
      else if (o !== e) begin n_fail++; $display("FAIL fmt64[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got[$];
    obs_t e;
    bit   ok1, ok2, acc;
    if32.out_ready = 1'b0;
    exp32.push_back('{64'h1, 3'd1, 64'h0, 64'h10, 1'b0});
    send(1'b0, 32'h00100093, 64'h10, ok1);
    exp32.push_back('{64'h2, 3'd1, 64'h0, 64'h14, 1'b0});
    send(1'b0, 32'h00200093, 64'h14, ok2);
    n_cmp++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept_two: got %b%b want 11", ok1, ok2); end
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready: got %b want 0", if32.in_ready); end
    exp32.push_back('{64'h3, 3'd1, 64'h0, 64'h18, 1'b0});
    if32.in_valid = 1'b1; if32.in_instr = 32'h00300093; if32.in_pc = 32'h18;
    @(posedge clk); #1;
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_third_in_ready: got %b want 0", if32.in_ready); end
    n_cmp++; if (if32.out_pc !== 32'h10 || if32.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_stable: got pc=%h v=%b want pc=10 v=1", if32.out_pc, if32.out_valid); end
    if32.out_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      acc = if32.in_valid && if32.in_ready;
      if (if32.out_valid) got.push_back(sample(1'b0));
      @(posedge clk); #1;
      if (acc) if32.in_valid = 1'b0;
    end
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b0;
    n_cmp++; if (got.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      e = exp32.pop_front();
      n_cmp++;
      if (k >= got.size()) begin n_fail++; $display("FAIL b2b_order[%0d]: got none want %h", k, e); end
      else if (got[k] !== e) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", k, got[k], e); end
    end
    @(posedge clk); #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got out_valid %b want 0", if32.out_valid); end
  endtask

  task automatic test_flush();
    obs_t o, e;
    bit   ok1, ok2, okc;
    if32.out_ready = 1'b0;
    send(1'b0, 32'h00100093, 64'h20, ok1);
    send(1'b0, 32'h00200093, 64'h24, ok2);
    n_cmp++; if (!(ok1 && ok2) || if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_fill: got ok=%b%b in_ready=%b want 11/0", ok1, ok2, if32.in_ready); end
    if32.in_valid = 1'b1; if32.in_instr = 32'h00300093; if32.in_pc = 32'h28;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if32.in_valid = 1'b0;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", if32.out_valid); end
    n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", if32.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_offered: got %b want 0", if32.out_valid); end
    exp32.push_back('{64'hFFFFFFFC, 3'd3, 64'h2C, 64'h30, 1'b0});
    send(1'b0, 32'hFE000EE3, 64'h30, ok1);
    collect(1'b0, o, okc);
    e = exp32.pop_front();
    n_cmp++;
    if (!ok1 || !okc) begin n_fail++; $display("FAIL flush_after: timeout send=%b collect=%b want 1/1", ok1, okc); end
    else if (o !== e) begin n_fail++; $display("FAIL flush_after: got %h want %h", o, e); end
  endtask

  task automatic test_reset_mid_stall();
    bit ok1, ok2;
    if32.out_ready = 1'b0;
    send(1'b0, 32'hFFF00093, 64'h40, ok1);
    send(1'b0, 32'h0080006F, 64'h44, ok2);
    n_cmp++; if (!(ok1 && ok2) || if32.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fill: got ok=%b%b v=%b want 11/1", ok1, ok2, if32.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", if32.out_valid); end
    n_cmp++; if (sample(1'b0) !== obs_t'(0)) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", sample(1'b0)); end
    n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready_hi: got %b want 0", if32.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got rdy=%b v=%b want 1/0", if32.in_ready, if32.out_valid); end
    n_cmp++; if (exp32.size() != 0 || exp64.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d/%0d want 0/0", exp32.size(), exp64.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_formats32();
    test_formats64();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
